adder_seq_ctrl: RTL and testbench

//   Sequencer for a wide add on the shared WIDTH-bit param_adder datapath.

---
 rtl/adder_seq_ctrl_if.sv | 27 ++
 rtl/adder_seq_ctrl.sv | 119 +++++++++++
 tb/tb_adder_seq_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/adder_seq_ctrl_if.sv
// Request/result bundle between a wide-add master and adder_seq_ctrl.
// Master drives the request and operands. The sequencer returns status and the result.
interface adder_seq_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
);
    localparam int N = WIDTH * WORDS;

    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Word-serial wide adder: one WIDTH-bit word per cycle, LSW first; done is WORDS cycles after accept.
// No backpressure: start is taken only in IDLE and is dropped, not queued, while RUN or DONE.
module param_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

module adder_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic            clk,
    input  logic            rst,
    adder_seq_ctrl_if.slave bus
);
    localparam int N  = WIDTH * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b;
    logic [N-1:0]     partial;
    logic             carry;
    logic             busy_q;
    logic             done_q;
    logic [N-1:0]     sum_q;
    logic             cout_q;

    logic [WIDTH-1:0] word_a;
    logic [WIDTH-1:0] word_b;
    logic [WIDTH-1:0] word_sum;
    logic             word_cout;
    logic [N-1:0]     partial_nxt;

    assign word_a = op_a[idx*WIDTH +: WIDTH];
    assign word_b = op_b[idx*WIDTH +: WIDTH];

    param_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (word_a),
        .b    (word_b),
        .cin  (carry),
        .sum  (word_sum),
        .cout (word_cout)
    );

    // Merging the current word here lets the last RUN edge publish the full sum directly.
    always_comb begin
        partial_nxt = partial;
        partial_nxt[idx*WIDTH +: WIDTH] = word_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            partial <= '0;
            carry   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_a   <= bus.a;
                        op_b   <= bus.b;
                        carry  <= bus.cin;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    partial <= partial_nxt;
                    carry   <= word_cout;
                    if (idx == LAST_IDX) begin
                        sum_q  <= partial_nxt;
                        cout_q <= word_cout;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        idx    <= '0;
                        state  <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed-vector and random bench for adder_seq_ctrl at WIDTH=4, WORDS=4.
module tb_adder_seq_ctrl;
    localparam int WIDTH = 4;
    localparam int WORDS = 4;
    localparam int N     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_seq_ctrl_if #(.WIDTH(WIDTH), .WORDS(WORDS)) bus ();

    adder_seq_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] s;
        logic         c;
    } vec_t;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int accepts  = 0;
    int cyc      = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    // Issues one op from IDLE and returns at the falling edge where done is seen.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                          input bit scramble, output logic [N-1:0] s, output logic c,
                          output int lat, output int bc, output bit to);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = cin;
        @(posedge clk);
        accepts++;
        #1 bus.start = 1'b0;
        lat = 0; bc = 0; to = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done) begin
                to = 1'b0;
                break;
            end
            if (bus.busy) bc++;
            if (scramble) begin
                bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
            end
            @(posedge clk);
            lat++;
        end
        s = bus.sum;
        c = bus.cout;
    endtask

    vec_t tbl[10];
    logic [N-1:0] s;
    logic         c;
    int           lat, bc, d1, d2, seen;
    bit           to;
    logic [16:0]  m;
    logic [N-1:0] ra, rb;
    logic         rc;

    initial begin
        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        tbl[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        tbl[4] = '{16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1};
        tbl[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        tbl[6] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
        tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        tbl[8] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[9] = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0};

        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum",  32'(bus.sum),  32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Table vectors; every third one scrambles the operand inputs during RUN.
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, (i % 3) == 2, s, c, lat, bc, to);
            chk($sformatf("v%0d_timeout", i), 32'(to), 32'd0);
            chk($sformatf("v%0d_sum", i), 32'(s), 32'(tbl[i].s));
            chk($sformatf("v%0d_cout", i), 32'(c), 32'(tbl[i].c));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
            chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd4);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
            chk($sformatf("v%0d_sum_held", i), 32'(bus.sum), 32'(tbl[i].s));
        end

        // Scrambled operands, then a start pulse confined to DONE must be ignored.
        run_op(16'h2468, 16'h1357, 1'b1, 1'b1, s, c, lat, bc, to);
        chk("t4_sum", 32'(s), 32'h37C0);
        chk("t4_cout", 32'(c), 32'd0);
        bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk);
        chk("t4_done_start_busy0", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("t4_done_start_busy1", 32'(bus.busy), 32'd0);
        chk("t4_done_start_done", 32'(bus.done), 32'd0);

        // Start held high: two back-to-back ops at the minimum issue interval.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 16'h8000; bus.b = 16'h8000; bus.cin = 1'b0;
        @(posedge clk); #1;
        bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b1;
        accepts += 2;
        to = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done) begin to = 1'b0; break; end
        end
        d1 = cyc;
        chk("t3_first_timeout", 32'(to), 32'd0);
        chk("t3_first_sum", 32'(bus.sum), 32'h0000);
        chk("t3_first_cout", 32'(bus.cout), 32'd1);
        @(posedge clk);
        to = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done) begin to = 1'b0; break; end
        end
        d2 = cyc;
        bus.start = 1'b0;
        chk("t3_second_timeout", 32'(to), 32'd0);
        chk("t3_interval", 32'(d2 - d1), 32'd6);
        chk("t3_second_sum", 32'(bus.sum), 32'h5556);
        chk("t3_second_cout", 32'(bus.cout), 32'd0);
        @(negedge clk);

        // Reset in the second RUN cycle aborts the op and clears the outputs.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 16'h0F0F; bus.b = 16'h0101; bus.cin = 1'b0;
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_done", 32'(bus.done), 32'd0);
        chk("t5_sum",  32'(bus.sum),  32'd0);
        chk("t5_cout", 32'(bus.cout), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        chk("t5_no_done", 32'(seen), 32'd0);
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, s, c, lat, bc, to);
        chk("t5_after_timeout", 32'(to), 32'd0);
        chk("t5_after_sum", 32'(s), 32'h0007);
        chk("t5_after_latency", 32'(lat), 32'd4);
        @(negedge clk);

        // Random ops with random idle gaps against an arithmetic model.
        for (int i = 0; i < 500; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            m  = {1'b0, ra} + {1'b0, rb} + 17'(rc);
            run_op(ra, rb, rc, 1'b1, s, c, lat, bc, to);
            chk($sformatf("rnd%0d_result a=%h b=%h cin=%0d", i, ra, rb, rc),
                32'({to, c, s}), 32'({1'b0, m}));
            @(negedge clk);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("done_count", 32'(done_cnt), 32'(accepts));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
